// File: rtl/ssp_tx_sequencer.sv
// SSP transmit sequencer: pops words from a show-ahead TX FIFO, generates sspclkout,
// and frames each word with a one-period FSS pulse followed by MSB-first data.
module ssp_tx_sequencer #(
  parameter int DATA_W   = 8,
  parameter int PRESCALE = 1
) (
  input  logic              pclk,
  input  logic              clear,
  input  logic              sse,
  input  logic              txhasword,
  input  logic [DATA_W-1:0] txdata,
  input  logic              rxfifoint,
  output logic              txfifo_pop,
  output logic              sspclkout,
  output logic              sspfssout,
  output logic              ssptxd,
  output logic              sspoe_b,
  output logic              busy,
  output logic              txdone
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    FSS,
    DATA
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sclk_q, sclk_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              fss_q, fss_d;
  logic              txd_q, txd_d;
  logic              oe_b_q, oe_b_d;

  logic run;
  logic half_end;
  logic tick;
  logic go;
  logic last_bit;
  logic load;

  // Clock runs while enabled or finishing a frame; tick marks the falling edge.
  always_comb begin
    run      = sse | (state_q != IDLE);
    half_end = run & (cnt_q == CNT_MAX);
    tick     = half_end & sclk_q;
    go       = sse & txhasword & ~rxfifoint;
    last_bit = (state_q == DATA) & (bitcnt_q == '0);
    cnt_d    = '0;
    sclk_d   = 1'b0;
    if (run) begin
      if (half_end) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        sclk_d = sclk_q;
      end
    end
  end

  always_ff @(posedge pclk or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sclk_q   <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      fss_q    <= 1'b0;
      txd_q    <= 1'b0;
      oe_b_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sclk_q   <= sclk_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      fss_q    <= fss_d;
      txd_q    <= txd_d;
      oe_b_q   <= oe_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (go) begin
            state_d = FSS;
            load    = 1'b1;
          end
        end
        FSS: state_d = DATA;
        DATA: begin
          if (bitcnt_q == '0) begin
            load    = go;
            state_d = go ? FSS : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A pop is combinational with the loading tick so shreg captures the show-ahead word
  // on the same edge the FIFO advances.
  always_comb begin
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    fss_d      = fss_q;
    txd_d      = txd_q;
    oe_b_d     = oe_b_q;
    txfifo_pop = load;
    txdone     = tick & last_bit;
    if (load) begin
      shreg_d = txdata;
      fss_d   = 1'b1;
      oe_b_d  = 1'b0;
      txd_d   = 1'b0;
    end else if (tick) begin
      case (state_q)
        FSS: begin
          fss_d    = 1'b0;
          txd_d    = shreg_q[DATA_W-1];
          bitcnt_d = BIT_MAX;
        end
        DATA: begin
          if (bitcnt_q != '0) begin
            shreg_d  = shreg_q << 1;
            txd_d    = shreg_q[DATA_W-2];
            bitcnt_d = bitcnt_q - 1'b1;
          end else begin
            oe_b_d = 1'b1;
            txd_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sspclkout = sclk_q;
    sspfssout = fss_q;
    ssptxd    = txd_q;
    sspoe_b   = oe_b_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_ssp_tx_sequencer.sv
// Bench for ssp_tx_sequencer: show-ahead FIFO model, serial scoreboard, frame timing checks.
module tb_ssp_tx_sequencer;
  localparam int DW = 8;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic          clear = 1'b0;
  logic          sse = 1'b0;
  logic          rxfifoint = 1'b0;
  logic          txhasword = 1'b0;
  logic [DW-1:0] txdata = '0;
  logic txfifo_pop, sspclkout, sspfssout, ssptxd, sspoe_b, busy, txdone;

  logic          sse_b = 1'b0;
  logic          b_avail = 1'b0;
  logic          b_taken = 1'b0;
  logic          rxfifoint_b = 1'b0;
  logic [DW-1:0] txdata_b = 8'h81;
  logic          txhasword_b;
  logic txfifo_pop_b, sspclkout_b, sspfssout_b, ssptxd_b, sspoe_b_b, busy_b, txdone_b;
  assign txhasword_b = b_avail & ~b_taken;

  ssp_tx_sequencer #(.DATA_W(DW), .PRESCALE(1)) dut (
    .pclk(pclk), .clear(clear), .sse(sse), .txhasword(txhasword), .txdata(txdata),
    .rxfifoint(rxfifoint), .txfifo_pop(txfifo_pop), .sspclkout(sspclkout),
    .sspfssout(sspfssout), .ssptxd(ssptxd), .sspoe_b(sspoe_b), .busy(busy), .txdone(txdone));

  ssp_tx_sequencer #(.DATA_W(DW), .PRESCALE(3)) dut_b (
    .pclk(pclk), .clear(clear), .sse(sse_b), .txhasword(txhasword_b), .txdata(txdata_b),
    .rxfifoint(rxfifoint_b), .txfifo_pop(txfifo_pop_b), .sspclkout(sspclkout_b),
    .sspfssout(sspfssout_b), .ssptxd(ssptxd_b), .sspoe_b(sspoe_b_b), .busy(busy_b),
    .txdone(txdone_b));

  logic [DW-1:0] fifo[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  logic pop_seen = 1'b0;
  int pops_n = 0, txdone_n = 0, illegal_n = 0, pops_b = 0;

  // Pre-edge view of the combinational strobes, exactly as the DUT acts on them.
  always @(posedge pclk) begin
    pop_seen <= txfifo_pop;
    if (txfifo_pop) begin
      pops_n <= pops_n + 1;
      if (!txhasword || rxfifoint) illegal_n <= illegal_n + 1;
    end
    if (txdone) txdone_n <= txdone_n + 1;
    if (txfifo_pop_b) begin
      b_taken <= 1'b1;
      pops_b  <= pops_b + 1;
    end
  end

  always @(negedge pclk) begin
    if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
    #1;
    txhasword = (fifo.size() != 0);
    txdata    = (fifo.size() != 0) ? fifo[0] : '0;
  end

  int oe_low_n = 0, fss_n = 0, busy_n = 0, oe_run = 0, last_run = 0, bitidx = 0;
  logic in_frame = 1'b0;
  logic prev_clk = 1'b0;
  logic [DW-1:0] shw = '0;

  always @(posedge pclk) begin
    #1;
    if (sspfssout) fss_n++;
    if (busy) busy_n++;
    if (!sspoe_b) begin
      oe_low_n++;
      oe_run++;
    end else begin
      if (oe_run != 0) last_run = oe_run;
      oe_run = 0;
    end
    if (!clear) begin
      in_frame = 1'b0;
      bitidx   = 0;
    end else if (sspclkout && !prev_clk) begin
      if (sspfssout) begin
        in_frame = 1'b1;
        bitidx   = 0;
      end else if (in_frame) begin
        shw = {shw[DW-2:0], ssptxd};
        bitidx++;
        if (bitidx == DW) begin
          got_q.push_back(shw);
          in_frame = 1'b0;
        end
      end
    end
    prev_clk = sspclkout;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    bit started = 0;
    bit done = 0;
    while (k < budget && !done) begin
      @(posedge pclk);
      #1;
      if (busy) started = 1;
      else if (started) done = 1;
      k++;
    end
    @(negedge pclk);
    chk({nm, " frame_end_seen"}, int'(done), 1);
  endtask

  task automatic wait_bit(input string nm, input int n);
    int k = 0;
    while (k < 200 && !(in_frame && bitidx >= n)) begin
      @(posedge pclk);
      #2;
      k++;
    end
    @(negedge pclk);
    chk({nm, " reached_bit"}, int'(k < 200), 1);
  endtask

  task automatic check_sb(input string nm);
    logic [DW-1:0] w;
    int e;
    while (got_q.size() > 0) begin
      w = got_q.pop_front();
      e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
      chk({nm, " serial_word"}, int'(w), e);
    end
    chk({nm, " words_outstanding"}, exp_q.size(), 0);
  endtask

  function automatic int outs();
    return int'({sspclkout, sspfssout, ssptxd, sspoe_b, txfifo_pop, busy, txdone});
  endfunction

  typedef struct {
    logic [DW-1:0] word;
    int oe_low;
    int fss_hi;
    int pops;
    int dones;
  } vec_t;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int p0, d0, o0, f0, b0, k, hi, rise_n, r1, r2, nb, oecnt, txhi;
    logic prevb, inb, st;
    logic [DW-1:0] capb;

    vecs[0] = '{8'hA5, 18, 2, 1, 1};
    vecs[1] = '{8'h3C, 18, 2, 1, 1};
    vecs[2] = '{8'h00, 18, 2, 1, 1};
    vecs[3] = '{8'hFF, 18, 2, 1, 1};
    vecs[4] = '{8'h81, 18, 2, 1, 1};
    vecs[5] = '{8'h5A, 18, 2, 1, 1};

    repeat (3) @(negedge pclk);
    chk("reset_outputs", outs(), 7'b0001000);
    clear = 1'b1;
    sse   = 1'b1;
    repeat (4) @(negedge pclk);
    chk("idle_no_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      p0 = pops_n; d0 = txdone_n; o0 = oe_low_n; f0 = fss_n;
      push(vecs[i].word);
      wait_done("single", 100);
      chk("single pops", pops_n - p0, vecs[i].pops);
      chk("single txdone", txdone_n - d0, vecs[i].dones);
      chk("single oe_low_pclk", oe_low_n - o0, vecs[i].oe_low);
      chk("single fss_high_pclk", fss_n - f0, vecs[i].fss_hi);
      check_sb("single");
    end

    p0 = pops_n; d0 = txdone_n; f0 = fss_n;
    push(8'hFF);
    push(8'h00);
    wait_done("b2b", 200);
    chk("b2b pops", pops_n - p0, 2);
    chk("b2b txdone", txdone_n - d0, 2);
    chk("b2b oe_contiguous", last_run, 36);
    chk("b2b fss_high_pclk", fss_n - f0, 4);
    check_sb("b2b");

    rxfifoint = 1'b1;
    p0 = pops_n; b0 = busy_n;
    push(8'h3C);
    repeat (40) @(negedge pclk);
    chk("rxfull pops", pops_n - p0, 0);
    chk("rxfull busy_pclk", busy_n - b0, 0);
    rxfifoint = 1'b0;
    k = 0;
    while (k < 4 && !busy) begin
      @(posedge pclk);
      #1;
      k++;
    end
    chk("rxrelease start_within_tick", int'(busy), 1);
    wait_done("rxrelease", 100);
    chk("rxrelease pops", pops_n - p0, 1);
    check_sb("rxrelease");

    p0 = pops_n; d0 = txdone_n;
    push(8'h96);
    push(8'h69);
    wait_bit("sse_drop", 3);
    sse = 1'b0;
    wait_done("sse_drop", 100);
    chk("sse_drop pops", pops_n - p0, 1);
    chk("sse_drop txdone", txdone_n - d0, 1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge pclk);
      #1;
      if (sspclkout) hi++;
    end
    @(negedge pclk);
    chk("sse_drop clk_parked_low", hi, 0);
    chk("sse_drop oe_b", int'(sspoe_b), 1);
    chk("sse_drop busy", int'(busy), 0);
    exp_q.delete(1);
    check_sb("sse_drop");
    exp_q.push_back(8'h69);
    sse = 1'b1;
    wait_done("resume", 100);
    check_sb("resume");

    push(8'hC3);
    wait_bit("reset_mid", 2);
    clear = 1'b0;
    #1;
    chk("reset_mid outputs", outs(), 7'b0001000);
    void'(exp_q.pop_front());
    push(8'hE7);
    repeat (2) @(negedge pclk);
    p0 = pops_n;
    clear = 1'b1;
    k = 0;
    while (k < 6 && !busy) begin
      @(posedge pclk);
      #1;
      k++;
    end
    chk("reset_release start_pclk", k, 2);
    wait_done("reset_release", 100);
    chk("reset_release pops", pops_n - p0, 1);
    check_sb("reset_release");
    chk("no_illegal_pops", illegal_n, 0);

    sse_b = 1'b1;
    b_avail = 1'b1;
    prevb = 1'b0; inb = 1'b0; st = 1'b0; capb = '0;
    rise_n = 0; r1 = 0; r2 = 0; nb = 0; oecnt = 0; txhi = 0;
    k = 0;
    while (k < 400 && !(st && !busy_b)) begin
      @(posedge pclk);
      #1;
      k++;
      if (busy_b) st = 1'b1;
      if (!sspoe_b_b) oecnt++;
      if (ssptxd_b) txhi++;
      if (sspclkout_b && !prevb) begin
        rise_n++;
        if (rise_n == 1) r1 = k;
        if (rise_n == 2) r2 = k;
        if (sspfssout_b) begin
          inb = 1'b1;
          nb = 0;
        end else if (inb && nb < DW) begin
          capb = {capb[DW-2:0], ssptxd_b};
          nb++;
        end
      end
      prevb = sspclkout_b;
    end
    @(negedge pclk);
    sse_b = 1'b0;
    chk("ps3 frame_end_seen", int'(st && !busy_b), 1);
    chk("ps3 sclk_period_pclk", r2 - r1, 6);
    chk("ps3 oe_low_pclk", oecnt, 54);
    chk("ps3 serial_word", int'(capb), 8'h81);
    chk("ps3 txd_high_pclk", txhi, 12);
    chk("ps3 pops", pops_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
